ff_excitation_driver: RTL and testbench
=======================================

// Module: ff_excitation_driver
// PURPOSE
//  Inverse of the flip-flop library: takes a requested next-state word and generates the
//  excitation inputs (D, S/R, J/K or T) that move a WIDTH-bit bank of library flip-flops there.
//  Sits between a controller issuing target states and a flip-flop bank, and reads the bank's q back.
//  Handles one target at a time: drive one excitation cycle, wait, then check q against target.
// PARAMETERS
//  WIDTH       8   bits in the driven flip-flop bank
//  FF_TYPE     2   bank type: 0=D, 1=SR, 2=JK, 3=T
//  SETTLE_CYC  1   cycles between the excitation strobe and the q check; legal range 1..15
// PORTS
//  clk        in   1      clock; all state updates on posedge clk
//  rst_n      in   1      synchronous reset, active-low
//  tgt_valid  in   1      target word offered
//  tgt_data   in   WIDTH  requested next state of the bank
//  tgt_ready  out  1      driver idle and able to accept a target
//  q_i        in   WIDTH  q outputs of the driven bank (feedback)
//  d_o        out  WIDTH  D excitation (FF_TYPE=0)
//  s_o, r_o   out  WIDTH  SR excitation (FF_TYPE=1)
//  j_o, k_o   out  WIDTH  JK excitation (FF_TYPE=2)
//  t_o        out  WIDTH  T excitation (FF_TYPE=3)
//  done       out  1      one-cycle pulse when a transition completes
//  mismatch   out  1      one-cycle pulse, coincident with done, when q_i != target
//  cur_state  out  WIDTH  driver's model of the bank state
// BEHAVIOUR
//  Reset (rst_n=0 at a posedge):
//   state=IDLE, cur_state=0, all excitation outputs=0, done=mismatch=0, and any in-flight target is dropped.
//   This also applies to a reset in the middle of an operation. Model matches the bank reset value 0.
//  FSM: IDLE -> DRIVE -> SETTLE -> CHECK -> IDLE.
//   IDLE: tgt_ready=1. On tgt_valid&tgt_ready, capture tgt_data into tgt_q and go to DRIVE.
//    Otherwise stay in IDLE.
//   DRIVE (exactly 1 cycle): excitation is computed from q=cur_state, t=tgt_q, per bit:
//    D:  d=t
//    SR: s=~q&t, r=q&~t; never s=r=1
//    JK: j=~q&t, k=q&~t; don't-cares resolve to 0, so j=k=1 is never produced
//    T:  t_o=q^t
//   SETTLE: SETTLE_CYC cycles, counted by a down-counter.
//    s/r/j/k/t outputs are all 0 (hold code). d_o keeps its tgt_q value (D has no hold code).
//   CHECK (1 cycle): done=1; q_i is compared with tgt_q; next state is IDLE.
//  Outputs not belonging to FF_TYPE are held at 0 in every state.
//  d_o holds the last target after CHECK until a new DRIVE or reset.
//  Latency: accept at edge N -> DRIVE in cycle N+1 -> done in cycle N+2+SETTLE_CYC ->
//   tgt_ready=1 again in the following cycle. Maximum rate: one target per SETTLE_CYC+3 cycles.
//  Target equal to cur_state: full sequence still runs, excitation is all zero (D: d=t), and done pulses.
//  tgt_ready=0 outside IDLE; tgt_valid/tgt_data are ignored there and need not be held.
//  tgt_valid and rst_n=0 in the same cycle: reset wins and nothing is captured.
// CONFIGURATION
//  FF_DRV_SELFCHECK_EN defined:
//   In CHECK, mismatch = (q_i != tgt_q) and cur_state <= q_i (model resyncs to the real bank).
//  FF_DRV_SELFCHECK_EN undefined:
//   mismatch is tied to 0, q_i is unused, and cur_state <= tgt_q in CHECK (open loop).
// TESTING  (WIDTH=4, SETTLE_CYC=1 unless noted; bench models the bank with library flip-flops)
//  1. Reset; JK; target 4'b1010 -> j_o=1010, k_o=0000 for one cycle; done after 3 cycles;
//     cur_state=1010; mismatch=0.
//  2. JK from 1010, target 0110 -> j_o=0100, k_o=1000 in DRIVE; both 0 in SETTLE; cur_state=0110.
//  3. SR from 0000: 1111 then 0000 -> s_o=1111, r_o=0000, then s_o=0000, r_o=1111;
//     s_o&r_o is always 0.
//  4. T, SETTLE_CYC=3, target 0101 from 0000 -> t_o=0101 for exactly 1 cycle;
//     done 5 cycles after accept; tgt_ready low for 5 cycles.
//  5. SELFCHECK_EN; bench forces q_i=0011 for target 0111 -> mismatch=1 with done;
//     cur_state=0011; next target 0111 gives j_o=0100.
//  6. Assert rst_n=0 during SETTLE -> next cycle: IDLE, tgt_ready=1, outputs 0, cur_state=0, no done pulse.

Source files
------------

// File: rtl/ff_excitation_driver.sv
// Excitation generator for a bank of D/SR/JK/T flip-flops: drives one target per transaction and checks q.
// Optional FF_DRV_SELFCHECK_EN: compare q_i in CHECK, flag mismatch and resync the model to the bank.
//
// state  | meaning
// IDLE   | ready for a target
// DRIVE  | excitation applied for one cycle
// SETTLE | hold code for SETTLE_CYC cycles
// CHECK  | done pulse, model update
module ff_excitation_driver #(
  parameter int WIDTH      = 8,
  parameter int FF_TYPE    = 2,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_i,
  output logic [WIDTH-1:0] d_o,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] j_o,
  output logic [WIDTH-1:0] k_o,
  output logic [WIDTH-1:0] t_o,
  output logic             done,
  output logic             mismatch,
  output logic [WIDTH-1:0] cur_state
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] chk_val;
  logic [WIDTH-1:0] rise, fall;
  logic [3:0]       cnt;

`ifdef FF_DRV_SELFCHECK_EN
  assign chk_val  = q_i;
  assign mismatch = (state == CHECK) && (q_i != tgt_q);
`else
  logic unused_q;
  assign unused_q = ^q_i;
  assign chk_val  = tgt_q;
  assign mismatch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      tgt_q     <= '0;
      cur_state <= '0;
      cnt       <= 4'd0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && tgt_valid)
        tgt_q <= tgt_data;
      if (state == DRIVE)
        cnt <= 4'(SETTLE_CYC - 1);
      else if (state == SETTLE && cnt != 4'd0)
        cnt <= cnt - 4'd1;
      if (state == CHECK)
        cur_state <= chk_val;
    end
  end

  always_comb begin
    state_nxt = state;
    tgt_ready = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        tgt_ready = 1'b1;
        if (tgt_valid) state_nxt = DRIVE;
      end
      DRIVE:  state_nxt = SETTLE;
      SETTLE: if (cnt == 4'd0) state_nxt = CHECK;
      CHECK: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Only 0->1 and 1->0 bits are excited; don't-cares resolve to 0 so S=R=1 and J=K=1 never occur.
  assign rise = ~cur_state & tgt_q;
  assign fall = cur_state & ~tgt_q;

  always_comb begin
    d_o = '0;
    s_o = '0;
    r_o = '0;
    j_o = '0;
    k_o = '0;
    t_o = '0;
    if (FF_TYPE == 0) begin
      d_o = tgt_q;
    end else if (state == DRIVE) begin
      if (FF_TYPE == 1) begin
        s_o = rise;
        r_o = fall;
      end else if (FF_TYPE == 2) begin
        j_o = rise;
        k_o = fall;
      end else begin
        t_o = cur_state ^ tgt_q;
      end
    end
  end

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Directed bench: four driver instances (JK, SR, T with long settle, D) each steering a modelled flip-flop bank.
module tb_ff_excitation_driver;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef FF_DRV_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic         jk_valid = 1'b0, jk_ready, jk_done, jk_mis;
  logic [W-1:0] jk_data = '0, jk_q_i, jk_d, jk_s, jk_r, jk_j, jk_k, jk_t, jk_cur, jk_bank;
  logic         jk_force_en = 1'b0;
  logic [W-1:0] jk_force_val = '0;
  logic         sr_valid = 1'b0, sr_ready, sr_done, sr_mis;
  logic [W-1:0] sr_data = '0, sr_d, sr_s, sr_r, sr_j, sr_k, sr_t, sr_cur, sr_bank;
  logic         tt_valid = 1'b0, tt_ready, tt_done, tt_mis;
  logic [W-1:0] tt_data = '0, tt_d, tt_s, tt_r, tt_j, tt_k, tt_t, tt_cur, tt_bank;
  logic         dd_valid = 1'b0, dd_ready, dd_done, dd_mis;
  logic [W-1:0] dd_data = '0, dd_d, dd_s, dd_r, dd_j, dd_k, dd_t, dd_cur, dd_bank;

  assign jk_q_i = jk_force_en ? jk_force_val : jk_bank;

  ff_excitation_driver #(.WIDTH(W), .FF_TYPE(2), .SETTLE_CYC(1)) u_jk (
    .clk(clk), .rst_n(rst_n), .tgt_valid(jk_valid), .tgt_data(jk_data), .tgt_ready(jk_ready),
    .q_i(jk_q_i), .d_o(jk_d), .s_o(jk_s), .r_o(jk_r), .j_o(jk_j), .k_o(jk_k), .t_o(jk_t),
    .done(jk_done), .mismatch(jk_mis), .cur_state(jk_cur));

  ff_excitation_driver #(.WIDTH(W), .FF_TYPE(1), .SETTLE_CYC(1)) u_sr (
    .clk(clk), .rst_n(rst_n), .tgt_valid(sr_valid), .tgt_data(sr_data), .tgt_ready(sr_ready),
    .q_i(sr_bank), .d_o(sr_d), .s_o(sr_s), .r_o(sr_r), .j_o(sr_j), .k_o(sr_k), .t_o(sr_t),
    .done(sr_done), .mismatch(sr_mis), .cur_state(sr_cur));

  ff_excitation_driver #(.WIDTH(W), .FF_TYPE(3), .SETTLE_CYC(3)) u_tt (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tt_valid), .tgt_data(tt_data), .tgt_ready(tt_ready),
    .q_i(tt_bank), .d_o(tt_d), .s_o(tt_s), .r_o(tt_r), .j_o(tt_j), .k_o(tt_k), .t_o(tt_t),
    .done(tt_done), .mismatch(tt_mis), .cur_state(tt_cur));

  ff_excitation_driver #(.WIDTH(W), .FF_TYPE(0), .SETTLE_CYC(1)) u_dd (
    .clk(clk), .rst_n(rst_n), .tgt_valid(dd_valid), .tgt_data(dd_data), .tgt_ready(dd_ready),
    .q_i(dd_bank), .d_o(dd_d), .s_o(dd_s), .r_o(dd_r), .j_o(dd_j), .k_o(dd_k), .t_o(dd_t),
    .done(dd_done), .mismatch(dd_mis), .cur_state(dd_cur));

  // Flip-flop bank models, reset to 0 together with the drivers.
  always @(posedge clk) begin
    if (!rst_n) begin
      jk_bank <= '0;
      sr_bank <= '0;
      tt_bank <= '0;
      dd_bank <= '0;
    end else begin
      jk_bank <= (jk_j & ~jk_bank) | (~jk_k & jk_bank);
      sr_bank <= sr_s | (~sr_r & sr_bank);
      tt_bank <= tt_bank ^ tt_t;
      dd_bank <= dd_d;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_tests++; if (jk_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b exp 1", jk_ready); end
    n_tests++; if ({jk_j, jk_k} !== 8'h00) begin n_fail++; $display("FAIL reset_jk got %b exp 00000000", {jk_j, jk_k}); end
    n_tests++; if ({jk_done, jk_mis} !== 2'b00) begin n_fail++; $display("FAIL reset_done got %b exp 00", {jk_done, jk_mis}); end
    n_tests++; if (jk_cur !== 4'b0000) begin n_fail++; $display("FAIL reset_cur got %b exp 0000", jk_cur); end
    n_tests++; if (dd_d !== 4'b0000) begin n_fail++; $display("FAIL reset_d got %b exp 0000", dd_d); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_jk_basic();
    jk_valid = 1'b1;
    jk_data  = 4'b1010;
    tick();
    jk_valid = 1'b0;
    n_tests++; if (jk_ready !== 1'b0) begin n_fail++; $display("FAIL jk1_busy got %b exp 0", jk_ready); end
    n_tests++; if (jk_j !== 4'b1010) begin n_fail++; $display("FAIL jk1_j got %b exp 1010", jk_j); end
    n_tests++; if (jk_k !== 4'b0000) begin n_fail++; $display("FAIL jk1_k got %b exp 0000", jk_k); end
    tick();
    n_tests++; if ({jk_j, jk_k, jk_done} !== 9'b0) begin n_fail++; $display("FAIL jk1_settle got %b exp 0", {jk_j, jk_k, jk_done}); end
    tick();
    n_tests++; if (jk_done !== 1'b1) begin n_fail++; $display("FAIL jk1_done got %b exp 1", jk_done); end
    n_tests++; if (jk_mis !== 1'b0) begin n_fail++; $display("FAIL jk1_mis got %b exp 0", jk_mis); end
    tick();
    n_tests++; if ({jk_ready, jk_done} !== 2'b10) begin n_fail++; $display("FAIL jk1_idle got %b exp 10", {jk_ready, jk_done}); end
    n_tests++; if (jk_cur !== 4'b1010) begin n_fail++; $display("FAIL jk1_cur got %b exp 1010", jk_cur); end
  endtask

  task automatic test_jk_change();
    jk_valid = 1'b1;
    jk_data  = 4'b0110;
    tick();
    jk_valid = 1'b0;
    n_tests++; if (jk_j !== 4'b0100) begin n_fail++; $display("FAIL jk2_j got %b exp 0100", jk_j); end
    n_tests++; if (jk_k !== 4'b1000) begin n_fail++; $display("FAIL jk2_k got %b exp 1000", jk_k); end
    n_tests++; if ({jk_d, jk_s, jk_r, jk_t} !== 16'h0) begin n_fail++; $display("FAIL jk2_other got %h exp 0", {jk_d, jk_s, jk_r, jk_t}); end
    tick();
    n_tests++; if ({jk_j, jk_k} !== 8'h00) begin n_fail++; $display("FAIL jk2_settle got %b exp 0", {jk_j, jk_k}); end
    tick();
    n_tests++; if (jk_done !== 1'b1) begin n_fail++; $display("FAIL jk2_done got %b exp 1", jk_done); end
    tick();
    n_tests++; if (jk_cur !== 4'b0110) begin n_fail++; $display("FAIL jk2_cur got %b exp 0110", jk_cur); end
    // Target equal to the current state: zero excitation, sequence still completes.
    jk_valid = 1'b1;
    tick();
    jk_valid = 1'b0;
    n_tests++; if ({jk_ready, jk_j, jk_k} !== 9'b0) begin n_fail++; $display("FAIL jk_same_drive got %b exp 0", {jk_ready, jk_j, jk_k}); end
    tick();
    tick();
    n_tests++; if (jk_done !== 1'b1) begin n_fail++; $display("FAIL jk_same_done got %b exp 1", jk_done); end
    tick();
  endtask

  task automatic test_sr();
    logic [W-1:0] tg [2];
    logic [W-1:0] es [2];
    logic [W-1:0] er [2];
    tg[0] = 4'b1111; es[0] = 4'b1111; er[0] = 4'b0000;
    tg[1] = 4'b0000; es[1] = 4'b0000; er[1] = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      sr_valid = 1'b1;
      sr_data  = tg[i];
      tick();
      sr_valid = 1'b0;
      n_tests++; if (sr_s !== es[i]) begin n_fail++; $display("FAIL sr_s[%0d] got %b exp %b", i, sr_s, es[i]); end
      n_tests++; if (sr_r !== er[i]) begin n_fail++; $display("FAIL sr_r[%0d] got %b exp %b", i, sr_r, er[i]); end
      n_tests++; if ((sr_s & sr_r) !== 4'b0000) begin n_fail++; $display("FAIL sr_both[%0d] got %b exp 0000", i, sr_s & sr_r); end
      n_tests++; if ({sr_d, sr_j, sr_k, sr_t} !== 16'h0) begin n_fail++; $display("FAIL sr_other[%0d] got %h exp 0", i, {sr_d, sr_j, sr_k, sr_t}); end
      tick();
      n_tests++; if ({sr_s, sr_r} !== 8'h00) begin n_fail++; $display("FAIL sr_settle[%0d] got %b exp 0", i, {sr_s, sr_r}); end
      tick();
      n_tests++; if (sr_done !== 1'b1) begin n_fail++; $display("FAIL sr_done[%0d] got %b exp 1", i, sr_done); end
      tick();
      n_tests++; if (sr_cur !== tg[i]) begin n_fail++; $display("FAIL sr_cur[%0d] got %b exp %b", i, sr_cur, tg[i]); end
    end
  endtask

  task automatic test_t_settle3();
    logic [W-1:0] exp_t;
    tt_valid = 1'b1;
    tt_data  = 4'b0101;
    tick();
    tt_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      exp_t = (i == 1) ? 4'b0101 : 4'b0000;
      n_tests++; if (tt_t !== exp_t) begin n_fail++; $display("FAIL t_out[%0d] got %b exp %b", i, tt_t, exp_t); end
      n_tests++; if (tt_done !== (i == 5)) begin n_fail++; $display("FAIL t_done[%0d] got %b exp %b", i, tt_done, i == 5); end
      n_tests++; if (tt_ready !== (i == 6)) begin n_fail++; $display("FAIL t_ready[%0d] got %b exp %b", i, tt_ready, i == 6); end
      if (i < 6) tick();
    end
    n_tests++; if (tt_cur !== 4'b0101) begin n_fail++; $display("FAIL t_cur got %b exp 0101", tt_cur); end
  endtask

  task automatic test_selfcheck();
    logic [W-1:0] exp_cur;
    logic [W-1:0] exp_j;
    exp_cur = SC ? 4'b0011 : 4'b0111;
    exp_j   = SC ? 4'b0100 : 4'b0000;
    jk_force_en  = 1'b1;
    jk_force_val = 4'b0011;
    jk_valid = 1'b1;
    jk_data  = 4'b0111;
    tick();
    jk_valid = 1'b0;
    n_tests++; if (jk_j !== 4'b0001) begin n_fail++; $display("FAIL sc_j1 got %b exp 0001", jk_j); end
    tick();
    tick();
    n_tests++; if (jk_done !== 1'b1) begin n_fail++; $display("FAIL sc_done got %b exp 1", jk_done); end
    n_tests++; if (jk_mis !== SC) begin n_fail++; $display("FAIL sc_mis got %b exp %b", jk_mis, SC); end
    tick();
    jk_force_en = 1'b0;
    n_tests++; if (jk_mis !== 1'b0) begin n_fail++; $display("FAIL sc_mis_pulse got %b exp 0", jk_mis); end
    n_tests++; if (jk_cur !== exp_cur) begin n_fail++; $display("FAIL sc_cur got %b exp %b", jk_cur, exp_cur); end
    jk_valid = 1'b1;
    tick();
    jk_valid = 1'b0;
    n_tests++; if (jk_j !== exp_j) begin n_fail++; $display("FAIL sc_j2 got %b exp %b", jk_j, exp_j); end
    tick();
    tick();
    n_tests++; if ({jk_done, jk_mis} !== 2'b10) begin n_fail++; $display("FAIL sc_done2 got %b exp 10", {jk_done, jk_mis}); end
    tick();
  endtask

  task automatic test_back_to_back();
    dd_valid = 1'b1;
    dd_data  = 4'b0011;
    tick();
    dd_data = 4'b1100;
    n_tests++; if ({dd_ready, dd_d} !== 5'b00011) begin n_fail++; $display("FAIL b2b_drive got %b exp 00011", {dd_ready, dd_d}); end
    n_tests++; if ({dd_s, dd_r, dd_j, dd_k, dd_t} !== 20'h0) begin n_fail++; $display("FAIL b2b_other got %h exp 0", {dd_s, dd_r, dd_j, dd_k, dd_t}); end
    tick();
    n_tests++; if (dd_d !== 4'b0011) begin n_fail++; $display("FAIL b2b_settle_d got %b exp 0011", dd_d); end
    tick();
    n_tests++; if ({dd_done, dd_d} !== 5'b10011) begin n_fail++; $display("FAIL b2b_check got %b exp 10011", {dd_done, dd_d}); end
    tick();
    n_tests++; if ({dd_ready, dd_done, dd_d} !== 6'b100011) begin n_fail++; $display("FAIL b2b_idle got %b exp 100011", {dd_ready, dd_done, dd_d}); end
    n_tests++; if (dd_cur !== 4'b0011) begin n_fail++; $display("FAIL b2b_cur1 got %b exp 0011", dd_cur); end
    tick();
    dd_valid = 1'b0;
    n_tests++; if ({dd_ready, dd_d} !== 5'b01100) begin n_fail++; $display("FAIL b2b_drive2 got %b exp 01100", {dd_ready, dd_d}); end
    tick();
    tick();
    n_tests++; if (dd_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2 got %b exp 1", dd_done); end
    tick();
    n_tests++; if ({dd_ready, dd_d, dd_cur} !== 9'b111001100) begin n_fail++; $display("FAIL b2b_end got %b exp 111001100", {dd_ready, dd_d, dd_cur}); end
  endtask

  task automatic test_reset_mid();
    jk_valid = 1'b1;
    jk_data  = 4'b1000;
    tick();
    jk_valid = 1'b0;
    tick();
    n_tests++; if (jk_ready !== 1'b0) begin n_fail++; $display("FAIL rm_settle got %b exp 0", jk_ready); end
    rst_n    = 1'b0;
    jk_valid = 1'b1;
    jk_data  = 4'b1111;
    tick();
    n_tests++; if ({jk_ready, jk_done, jk_mis} !== 3'b100) begin n_fail++; $display("FAIL rm_state got %b exp 100", {jk_ready, jk_done, jk_mis}); end
    n_tests++; if ({jk_j, jk_k, jk_cur} !== 12'h0) begin n_fail++; $display("FAIL rm_out got %h exp 0", {jk_j, jk_k, jk_cur}); end
    n_tests++; if (dd_d !== 4'b0000) begin n_fail++; $display("FAIL rm_d got %b exp 0000", dd_d); end
    tick();
    rst_n    = 1'b1;
    jk_valid = 1'b0;
    n_tests++; if (jk_ready !== 1'b1) begin n_fail++; $display("FAIL rm_nocap got %b exp 1", jk_ready); end
    tick();
    n_tests++; if ({jk_ready, jk_done, jk_j} !== 6'b100000) begin n_fail++; $display("FAIL rm_after got %b exp 100000", {jk_ready, jk_done, jk_j}); end
  endtask

  initial begin
    test_reset();
    test_jk_basic();
    test_jk_change();
    test_sr();
    test_t_settle3();
    test_selfcheck();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
